logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, registered bitwise logic unit that generalises the team's single-bit two-input gates into one WIDTH-bit datapath with a runtime operation select. Operand pairs arrive on a valid/ready input handshake, and the result is computed in the same cycle. The result is buffered in a DEPTH-entry result FIFO and presented on a valid/ready output handshake. It sits between an operand producer and a result consumer wherever bitwise ops need flow control and backpressure.

## Interface
- WIDTH, default 8: operand and result width in bits, ≥1.
- DEPTH, default 4: result FIFO entries, power of two, ≥2.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair and op are valid.
- in_ready  output  1  unit can accept; registered, no combinational path from out_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored by NOT_A).
- op  input  3  operation select.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer accepts head.
- y  output  WIDTH  result at FIFO head.
- y_parity  output  1  XOR-reduce of y (LOGIC_UNIT_REDUCE_EN only, else 0).
- y_zero  output  1  y == 0 (LOGIC_UNIT_REDUCE_EN only, else 0).
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT_A, 111 ANDN (a & ~b). All codes are defined, and no error path exists.
- Push: in_valid && in_ready at a rising edge. The result f(op,a,b) is computed combinationally and written into the FIFO tail on that edge. Operands are not stored.
- Pop: out_valid && out_ready at a rising edge. The head advances.
- in_ready = (count < DEPTH), derived from registered count only.
- out_valid = (count != 0). y, y_parity and y_zero show head entry contents and hold stable while out_valid && !out_ready.
- Simultaneous push and pop: both occur, and count is unchanged. This is legal at any occupancy including full−1 and 1. When count == DEPTH, push is blocked even if a pop occurs in the same cycle. in_ready rises in the cycle after the pop.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is the separate occupancy register, 0..DEPTH.
- Data written to an unused slot is never visible on y.
- Reset mid-operation: all entries are discarded and pointers are cleared. No in-flight result survives.

## Timing
- Reset values: in_ready 0 while rst_n low, then 1 from the first clk edge after release. out_valid 0, y 0, y_parity 0, y_zero 0, count 0.
- Latency: a result pushed at edge N is visible with out_valid = 1 after edge N, i.e. in cycle N+1 when the FIFO was empty. There is no zero-latency bypass.
- Throughput: one op per cycle sustained when out_ready is held high.
- Full: after DEPTH pushes with no pops, in_ready = 0 starting the cycle after the DEPTH-th push.
- Producer must hold a, b, op and in_valid stable until accepted. The unit samples only on handshake.

## Configuration
- LOGIC_UNIT_REDUCE_EN defined: each FIFO entry stores WIDTH+2 bits, namely the result, parity (^result) and zero flag (result == 0), computed at push time. y_parity and y_zero reflect the head entry.
- Not defined: FIFO stores WIDTH bits only, and y_parity and y_zero are tied to 0. Ports remain present so that benches are identical in both configurations.

## Structure
- Package logic_unit_pkg holds the op code typedef (3-bit enum with the eight names above) and the function computing f(op,a,b) generically over WIDTH.
- Sub-module logic_unit_fifo is a generic synchronous FIFO. It has parameters W (entry width) and DEPTH, and provides push, pop, full, empty, count and head data with an asynchronous active-low reset. logic_unit_pipe instantiates it with W = WIDTH or WIDTH+2.

## Test plan
- Reset then one push per op with WIDTH=8, a=8'hA5, b=8'h0F, out_ready=1 → y sequence 05, AF, AA, 55, FA, 50, 5A, A0, each one cycle after its push.
- out_ready=0, push 5 ops with DEPTH=4 → first four accepted, in_ready=0 after the 4th, count=4. Raise out_ready → y drains in order, and in_ready returns the cycle after the first pop.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle → pop occurs, push refused, count 4→3. The next cycle push accepted, count stays 3 with continuous pop.
- Stream 3·DEPTH ops with random out_ready → no loss or reorder across pointer wrap, and y stalls stable while out_ready=0.
- Assert rst_n low with count=3 mid-stream → out_valid, count and y go 0 asynchronously, and the first push after release appears with latency 1.
- LOGIC_UNIT_REDUCE_EN: XOR a=8'hFF, b=8'hFF → y=00, y_zero=1, y_parity=0. Then OR a=8'h01, b=8'h00 → y=01, y_zero=0, y_parity=1. Without the macro, both flags are 0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the registered bitwise logic unit.
// Holds the op-code enum and the per-bit operation applied across any WIDTH.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_XNOR  = 3'b011,
    OP_NAND  = 3'b100,
    OP_NOR   = 3'b101,
    OP_NOT_A = 3'b110,
    OP_ANDN  = 3'b111
  } op_e;

  // One bit of f(op,a,b); callers loop this over WIDTH so any width is supported.
  function automatic logic lu_bit(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_XNOR:  r = ~(a ^ b);
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_NOT_A: r = ~a;
      OP_ANDN:  r = a & ~b;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_fifo.sv
// Generic synchronous FIFO: W-bit entries, DEPTH (power of two) slots.
// Head data reads as zero while empty so stale slots never leak out.
module logic_unit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation, masked while empty.
  always_comb begin
    if (empty) begin
      rdata = '0;
    end else begin
      rdata = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready in, result FIFO, valid/ready out.
// Define LOGIC_UNIT_REDUCE_EN to also store and present parity and zero flags.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic [2:0]             op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       y,
  output logic                   y_parity,
  output logic                   y_zero,
  output logic [$clog2(DEPTH):0] count
);

  import logic_unit_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef LOGIC_UNIT_REDUCE_EN
  localparam int EW = WIDTH + 2;
`else
  localparam int EW = WIDTH;
`endif

  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             in_ready_r;
  op_e              op_s;
  logic [WIDTH-1:0] res_s;
  logic [EW-1:0]    wdata_s;
  logic [EW-1:0]    rdata_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [CW-1:0]    count_s;
  logic [CW-1:0]    count_nxt_s;

  // Result computed from live operands; only the result is ever stored.
  always_comb begin
    op_s  = op_e'(op);
    res_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res_s[i] = lu_bit(op_s, a[i], b[i]);
    end
  end

  assign push_s = in_valid & in_ready_r & ~full_s;
  assign pop_s  = out_ready & ~empty_s;

  // Occupancy after this edge, used to register in_ready without out_ready in its path.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_s + CW'(1'b1);
      2'b01:   count_nxt_s = count_s - CW'(1'b1);
      default: count_nxt_s = count_s;
    endcase
  end

  // in_ready is low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b0;
    end else begin
      in_ready_r <= (count_nxt_s < DEPTH_C);
    end
  end

  // Entry packing and head unpacking for the configured entry layout.
  always_comb begin
`ifdef LOGIC_UNIT_REDUCE_EN
    wdata_s  = {(res_s == {WIDTH{1'b0}}), parity_of(res_s), res_s};
    y        = rdata_s[WIDTH-1:0];
    y_parity = rdata_s[WIDTH];
    y_zero   = rdata_s[WIDTH+1];
`else
    wdata_s  = res_s;
    y        = rdata_s;
    y_parity = 1'b0;
    y_zero   = 1'b0;
`endif
  end

  logic_unit_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s),
    .rdata (rdata_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = ~empty_s;
  assign count     = count_s;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe; flag expectations follow LOGIC_UNIT_REDUCE_EN.
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] op = 3'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] y;
  logic       y_parity;
  logic       y_zero;
  logic [2:0] count;

  logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_parity(y_parity), .y_zero(y_zero), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       p;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   stream_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w);
    case (o)
      3'd0:    return x & w;
      3'd1:    return x | w;
      3'd2:    return x ^ w;
      3'd3:    return ~(x ^ w);
      3'd4:    return ~(x & w);
      3'd5:    return ~(x | w);
      3'd6:    return ~x;
      default: return x & ~w;
    endcase
  endfunction

  function automatic exp_t mk(input logic [7:0] v);
    exp_t e;
    e.y = v;
`ifdef LOGIC_UNIT_REDUCE_EN
    e.p = ^v;
    e.z = (v == 8'h00);
`else
    e.p = 1'b0;
    e.z = 1'b0;
`endif
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_push(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w,
                         input logic [7:0] want);
    bit acc;
    acc = 1'b0;
    a = x;
    b = w;
    op = o;
    in_valid = 1'b1;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(mk(want));
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("push_accepted", {31'd0, acc}, 32'd1);
  endtask

  // Monitor: compare head against scoreboard; pop only on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        check(out_ready ? "y" : "y_stall", {24'd0, y}, {24'd0, exp_q[0].y});
        check("y_parity", {31'd0, y_parity}, {31'd0, exp_q[0].p});
        check("y_zero", {31'd0, y_zero}, {31'd0, exp_q[0].z});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] sw_exp [8];
    logic [7:0] x;
    logic [7:0] w;
    logic [2:0] o;
    sw_exp[0] = 8'h05; sw_exp[1] = 8'hAF; sw_exp[2] = 8'hAA; sw_exp[3] = 8'h55;
    sw_exp[4] = 8'hFA; sw_exp[5] = 8'h50; sw_exp[6] = 8'h5A; sw_exp[7] = 8'hA0;

    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_flags", {30'd0, y_parity, y_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Op sweep, streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = 3'(i);
      do_push(o, 8'hA5, 8'h0F, sw_exp[i]);
      check("sweep_count", {29'd0, count}, 32'd1);
    end
    @(posedge clk); #1;
    check("sweep_drain_count", {29'd0, count}, 32'd0);

    // Backpressure to full
    out_ready = 1'b0;
    do_push(3'd0, 8'h3C, 8'hF0, 8'h30);
    do_push(3'd1, 8'h3C, 8'hF0, 8'hFC);
    do_push(3'd2, 8'h3C, 8'hF0, 8'hCC);
    do_push(3'd5, 8'h3C, 8'hF0, 8'h03);
    check("full_count", {29'd0, count}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    a = 8'h3C; b = 8'hF0; op = 3'd4; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("full_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    // Pop while full: push refused this edge, accepted the next
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("after_pop_count", {29'd0, count}, 32'd3);
    check("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    if (in_ready) exp_q.push_back(mk(8'hCF));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("push_pop_count", {29'd0, count}, 32'd3);
    for (int k = 0; k < 20 && count != 3'd0; k++) begin
      @(posedge clk); #1;
    end
    check("drain2_count", {29'd0, count}, 32'd0);

    // Stream across pointer wrap with random out_ready
    stream_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          x = 8'(i * 19 + 7);
          w = 8'((i * 41) ^ 8'h5A);
          o = 3'(i);
          do_push(o, x, w, model(o, x, w));
        end
        stream_on = 1'b0;
      end
      begin
        while (stream_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 20 && count != 3'd0; k++) begin
      @(posedge clk); #1;
    end
    check("stream_drain_count", {29'd0, count}, 32'd0);
    check("stream_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset with three results buffered
    out_ready = 1'b0;
    do_push(3'd3, 8'h12, 8'h34, 8'hD9);
    do_push(3'd7, 8'hF0, 8'h30, 8'hC0);
    do_push(3'd6, 8'h0F, 8'h00, 8'hF0);
    check("pre_reset_count", {29'd0, count}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_y", {24'd0, y}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    do_push(3'd2, 8'hFF, 8'hFF, 8'h00);
    check("post_rst_latency", {31'd0, out_valid}, 32'd1);
    check("post_rst_count", {29'd0, count}, 32'd1);
    do_push(3'd1, 8'h01, 8'h00, 8'h01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("final_count", {29'd0, count}, 32'd0);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
